// File: rtl/mem_access_arbiter.sv
// Four-executer memory port arbiter; MEM_ARB_ROUND_ROBIN_EN selects round-robin, else fixed 0>1>2>3.
// Latency: request seen in IDLE -> mem_valid next cycle; ack_pulse the cycle after mem_done.
// Backpressure: latched request held in ISSUE until mem_ready; executers hold req_valid until ack_pulse.
module mem_access_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 16
) (
  input  logic                   main_clk,
  input  logic                   main_reset_n,
  input  logic [3:0]             req_valid,
  input  logic [3:0]             req_is_stack,
  input  logic [3:0]             req_write,
  input  logic [3:0]             req_byte,
  input  logic [3:0][ADDR_W-1:0] req_addr,
  input  logic [3:0][DATA_W-1:0] req_data,
  output logic                   mem_valid,
  input  logic                   mem_ready,
  output logic                   mem_is_stack,
  output logic                   mem_write,
  output logic                   mem_byte,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_data,
  output logic [1:0]             mem_owner,
  input  logic                   mem_done,
  output logic [3:0]             will_ack_pulse,
  output logic [3:0]             ack_pulse
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  typedef struct packed {
    logic              is_stack;
    logic              write;
    logic              byte_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  logic [1:0] state;
  req_t       cur;
  logic [3:0] eligible;
  logic       grant_vld;
  logic [1:0] grant_idx;
  logic [1:0] prio_base;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic [1:0] rr_ptr;

  always_ff @(posedge main_clk or negedge main_reset_n) begin
    if (!main_reset_n) begin
      rr_ptr <= 2'd0;
    end else if (grant_vld) begin
      rr_ptr <= grant_idx + 2'd1;
    end
  end

  assign prio_base = rr_ptr;
`else
  assign prio_base = 2'd0;
`endif

  // The executer being acked still shows its old req_valid this cycle; keep it out.
  assign eligible = (state == IDLE) ? (req_valid & ~ack_pulse) : 4'b0000;

  // Walk from lowest to highest priority so the highest-priority hit wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (eligible[prio_base + 2'(k)]) begin
        grant_vld = 1'b1;
        grant_idx = prio_base + 2'(k);
      end
    end
  end

  assign mem_valid      = (state == ISSUE);
  assign mem_is_stack   = cur.is_stack;
  assign mem_write      = cur.write;
  assign mem_byte       = cur.byte_en;
  assign mem_addr       = cur.addr;
  assign mem_data       = cur.data;
  assign will_ack_pulse = (state == WAIT && mem_done) ? (4'b0001 << mem_owner) : 4'b0000;

  always_ff @(posedge main_clk or negedge main_reset_n) begin
    if (!main_reset_n) begin
      state     <= IDLE;
      cur       <= '0;
      mem_owner <= 2'd0;
      ack_pulse <= 4'b0000;
    end else begin
      ack_pulse <= will_ack_pulse;
      case (state)
        IDLE: begin
          if (grant_vld) begin
            state     <= ISSUE;
            mem_owner <= grant_idx;
            cur       <= '{is_stack: req_is_stack[grant_idx],
                           write:    req_write[grant_idx],
                           byte_en:  req_byte[grant_idx],
                           addr:     req_addr[grant_idx],
                           data:     req_data[grant_idx]};
          end
        end
        ISSUE: begin
          if (mem_ready) state <= WAIT;
        end
        WAIT: begin
          if (mem_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_arbiter.sv
// Bench for mem_access_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_mem_access_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 16;

  logic                   main_clk = 1'b0;
  logic                   main_reset_n;
  logic [3:0]             req_valid, req_is_stack, req_write, req_byte;
  logic [3:0][ADDR_W-1:0] req_addr;
  logic [3:0][DATA_W-1:0] req_data;
  logic                   mem_valid, mem_ready, mem_is_stack, mem_write, mem_byte;
  logic [ADDR_W-1:0]      mem_addr;
  logic [DATA_W-1:0]      mem_data;
  logic [1:0]             mem_owner;
  logic                   mem_done;
  logic [3:0]             will_ack_pulse, ack_pulse;

  int checks = 0;
  int errors = 0;

  always #5 main_clk = ~main_clk;

  mem_access_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .main_clk(main_clk), .main_reset_n(main_reset_n),
    .req_valid(req_valid), .req_is_stack(req_is_stack), .req_write(req_write),
    .req_byte(req_byte), .req_addr(req_addr), .req_data(req_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_is_stack(mem_is_stack),
    .mem_write(mem_write), .mem_byte(mem_byte), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_owner(mem_owner), .mem_done(mem_done),
    .will_ack_pulse(will_ack_pulse), .ack_pulse(ack_pulse)
  );

  task automatic tick();
    @(posedge main_clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_valid = '0; req_is_stack = '0; req_write = '0; req_byte = '0;
    req_addr = '0; req_data = '0; mem_ready = 1'b0; mem_done = 1'b0;
  endtask

  task automatic randomize_req(input int i);
    req_is_stack[i] = 1'($urandom_range(1, 0));
    req_write[i]    = 1'($urandom_range(1, 0));
    req_byte[i]     = 1'($urandom_range(1, 0));
    req_addr[i]     = ADDR_W'($urandom);
    req_data[i]     = DATA_W'($urandom);
  endtask

  // Reset released mid-cycle, so the next edge is the first one with reset high.
  task automatic do_reset();
    main_reset_n = 1'b0;
    clear_inputs();
    @(posedge main_clk);
    @(posedge main_clk);
    #1;
    main_reset_n = 1'b1;
  endtask

  // Highest-priority eligible requester, scanning base, base+1, ... mod 4.
  function automatic int pick(input logic [3:0] elig, input int base);
    for (int k = 0; k < 4; k++) if (elig[(base + k) % 4]) return (base + k) % 4;
    return -1;
  endfunction

  task automatic test_reset();
    main_reset_n = 1'b0;
    req_valid = 4'hF; mem_ready = 1'b1; mem_done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      randomize_req(i);
    end
    tick(); tick();
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", mem_valid); end
    checks++; if (mem_owner !== 2'd0) begin errors++; $display("FAIL reset_owner: got %0d expected 0", mem_owner); end
    checks++; if ({mem_is_stack, mem_write, mem_byte} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {mem_is_stack, mem_write, mem_byte}); end
    checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_addr: got %h expected 0", mem_addr); end
    checks++; if (mem_data !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", mem_data); end
    checks++; if (will_ack_pulse !== 4'b0000) begin errors++; $display("FAIL reset_will_ack: got %b expected 0000", will_ack_pulse); end
    checks++; if (ack_pulse !== 4'b0000) begin errors++; $display("FAIL reset_ack: got %b expected 0000", ack_pulse); end
    clear_inputs();
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 4'b0100; req_addr[2] = 32'h0000_1234; req_write[2] = 1'b1; req_data[2] = 16'hBEEF;
    tick();
    checks++; if (mem_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %0b expected 1", mem_valid); end
    checks++; if (mem_owner !== 2'd2) begin errors++; $display("FAIL single_owner: got %0d expected 2", mem_owner); end
    checks++; if (mem_addr !== 32'h0000_1234) begin errors++; $display("FAIL single_addr: got %h expected 00001234", mem_addr); end
    checks++; if (mem_data !== 16'hBEEF) begin errors++; $display("FAIL single_data: got %h expected beef", mem_data); end
    checks++; if ({mem_is_stack, mem_write, mem_byte} !== 3'b010) begin errors++; $display("FAIL single_flags: got %b expected 010", {mem_is_stack, mem_write, mem_byte}); end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL single_wait_valid: got %0b expected 0", mem_valid); end
    mem_done = 1'b1;
    #1;
    checks++; if (will_ack_pulse !== 4'b0100) begin errors++; $display("FAIL single_will_ack: got %b expected 0100", will_ack_pulse); end
    checks++; if (ack_pulse !== 4'b0000) begin errors++; $display("FAIL single_ack_early: got %b expected 0000", ack_pulse); end
    tick();
    mem_done = 1'b0;
    #1;
    checks++; if (ack_pulse !== 4'b0100) begin errors++; $display("FAIL single_ack: got %b expected 0100", ack_pulse); end
    checks++; if (will_ack_pulse !== 4'b0000) begin errors++; $display("FAIL single_will_ack_after: got %b expected 0000", will_ack_pulse); end
    // req_valid[2] left high through the ack cycle: it is stale and must not re-grant.
    tick();
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL single_stale_regrant: got %0b expected 0", mem_valid); end
    checks++; if (ack_pulse !== 4'b0000) begin errors++; $display("FAIL single_ack_width: got %b expected 0000", ack_pulse); end
    clear_inputs();
  endtask

  task automatic test_backpressure();
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    do_reset();
    a = 32'hCAFE_0010; d = 16'h5A5A;
    req_valid = 4'b0010; req_addr[1] = a; req_data[1] = d; req_is_stack[1] = 1'b1; req_byte[1] = 1'b1;
    tick();
    for (int c = 0; c < 5; c++) begin
      checks++; if (mem_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: cycle %0d got %0b expected 1", c, mem_valid); end
      checks++; if ({mem_owner, mem_addr, mem_data} !== {2'd1, a, d}) begin errors++; $display("FAIL bp_fields: cycle %0d got %0d/%h/%h expected 1/%h/%h", c, mem_owner, mem_addr, mem_data, a, d); end
      checks++; if ({mem_is_stack, mem_write, mem_byte} !== 3'b101) begin errors++; $display("FAIL bp_flags: cycle %0d got %b expected 101", c, {mem_is_stack, mem_write, mem_byte}); end
      req_addr[1] = ~req_addr[1];
      req_data[1] = DATA_W'($urandom);
      req_is_stack[1] = ~req_is_stack[1];
      tick();
    end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0; mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    checks++; if (ack_pulse !== 4'b0010) begin errors++; $display("FAIL bp_ack: got %b expected 0010", ack_pulse); end
    clear_inputs();
    tick();
  endtask

  task automatic test_done_ignored();
    do_reset();
    mem_done = 1'b1;
    #1;
    checks++; if (will_ack_pulse !== 4'b0000) begin errors++; $display("FAIL idle_done_will_ack: got %b expected 0000", will_ack_pulse); end
    tick();
    mem_done = 1'b0;
    checks++; if ({mem_valid, ack_pulse} !== 5'b0) begin errors++; $display("FAIL idle_done_effect: got valid %0b ack %b expected 0 0000", mem_valid, ack_pulse); end
    req_valid = 4'b1000; randomize_req(3);
    tick();
    checks++; if ({mem_valid, mem_owner} !== 3'b111) begin errors++; $display("FAIL issue_grant: got valid %0b owner %0d expected 1 3", mem_valid, mem_owner); end
    mem_done = 1'b1;
    #1;
    checks++; if (will_ack_pulse !== 4'b0000) begin errors++; $display("FAIL issue_done_will_ack: got %b expected 0000", will_ack_pulse); end
    tick();
    mem_done = 1'b0;
    checks++; if ({mem_valid, ack_pulse} !== 5'b10000) begin errors++; $display("FAIL issue_done_effect: got valid %0b ack %b expected 1 0000", mem_valid, ack_pulse); end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0; mem_done = 1'b1;
    #1;
    checks++; if (will_ack_pulse !== 4'b1000) begin errors++; $display("FAIL issue_then_will_ack: got %b expected 1000", will_ack_pulse); end
    tick();
    mem_done = 1'b0;
    checks++; if (ack_pulse !== 4'b1000) begin errors++; $display("FAIL issue_then_ack: got %b expected 1000", ack_pulse); end
    clear_inputs();
    tick();
  endtask

  task automatic test_grant_order();
    int exp_order[$];
    int n;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_order = '{0, 1, 2, 3, 0};
`else
    exp_order = '{0, 1, 2, 3};
`endif
    do_reset();
    req_valid = 4'hF; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      randomize_req(i);
    end
    for (int g = 0; g < exp_order.size(); g++) begin
      n = 0;
      tick();
      while (!mem_valid && n < 10) begin
        tick();
        n++;
      end
      checks++;
      if (mem_valid !== 1'b1) begin errors++; $display("FAIL order_timeout: grant %0d never issued", g); break; end
      checks++; if (mem_owner !== 2'(exp_order[g])) begin errors++; $display("FAIL order_owner: grant %0d got %0d expected %0d", g, mem_owner, exp_order[g]); end
      checks++; if (n !== 0) begin errors++; $display("FAIL order_latency: grant %0d got %0d idle cycles expected 0", g, n); end
      tick();
      mem_done = 1'b1;
      tick();
      mem_done = 1'b0;
      checks++; if (ack_pulse !== 4'(1 << exp_order[g])) begin errors++; $display("FAIL order_ack: grant %0d got %b expected %b", g, ack_pulse, 4'(1 << exp_order[g])); end
`ifndef MEM_ARB_ROUND_ROBIN_EN
      req_valid[exp_order[g]] = 1'b0;
`endif
    end
    req_valid = 4'b0000;
    tick(); tick();
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL order_drained: got %0b expected 0", mem_valid); end
    clear_inputs();
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    req_valid = 4'b0010; randomize_req(1); mem_ready = 1'b1;
    tick();
    checks++; if ({mem_valid, mem_owner} !== 3'b101) begin errors++; $display("FAIL rst_wait_grant: got valid %0b owner %0d expected 1 1", mem_valid, mem_owner); end
    tick();
    mem_ready = 1'b0;
    #2;
    main_reset_n = 1'b0;
    mem_done = 1'b1;
    #1;
    checks++; if ({mem_valid, mem_owner, mem_is_stack, mem_write, mem_byte} !== 6'b0) begin errors++; $display("FAIL rst_wait_ctrl: got valid %0b owner %0d flags %b expected all 0", mem_valid, mem_owner, {mem_is_stack, mem_write, mem_byte}); end
    checks++; if ({mem_addr, mem_data} !== '0) begin errors++; $display("FAIL rst_wait_fields: got %h/%h expected 0/0", mem_addr, mem_data); end
    checks++; if ({will_ack_pulse, ack_pulse} !== 8'b0) begin errors++; $display("FAIL rst_wait_acks: got %b/%b expected 0000/0000", will_ack_pulse, ack_pulse); end
    req_valid = 4'b0011; randomize_req(0); randomize_req(1);
    tick();
    mem_done = 1'b0;
    main_reset_n = 1'b1;
    tick();
    checks++; if ({mem_valid, mem_owner} !== 3'b100) begin errors++; $display("FAIL rst_release_grant: got valid %0b owner %0d expected 1 0", mem_valid, mem_owner); end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0; mem_done = 1'b1;
    #1;
    checks++; if (will_ack_pulse !== 4'b0001) begin errors++; $display("FAIL rst_release_will_ack: got %b expected 0001", will_ack_pulse); end
    tick();
    mem_done = 1'b0;
    checks++; if (ack_pulse !== 4'b0001) begin errors++; $display("FAIL rst_release_ack: got %b expected 0001 (no ack for abandoned owner 1)", ack_pulse); end
    req_valid[0] = 1'b0;
    tick();
    checks++; if ({mem_valid, mem_owner, ack_pulse} !== 7'b1010000) begin errors++; $display("FAIL rst_second_grant: got valid %0b owner %0d ack %b expected 1 1 0000", mem_valid, mem_owner, ack_pulse); end
    clear_inputs();
    do_reset();
  endtask

  // Transaction-level reference: phase 0 idle, 1 offered downstream, 2 awaiting completion.
  task automatic test_random();
    int phase, owner, base, w;
    logic [3:0] exp_ack, exp_will;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_data;
    logic [2:0] e_flags;
    do_reset();
    phase = 0; owner = 0; base = 0; exp_ack = 4'b0000;
    e_addr = '0; e_data = '0; e_flags = 3'b000;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (req_valid[i] && exp_ack[i]) begin
          if ($urandom_range(1, 0) == 0) req_valid[i] = 1'b0;
          else randomize_req(i);
        end else if (!req_valid[i] && $urandom_range(3, 0) == 0) begin
          req_valid[i] = 1'b1;
          randomize_req(i);
        end
      end
      mem_ready = 1'($urandom_range(1, 0));
      mem_done  = ($urandom_range(2, 0) == 0);
      #1;
      exp_will = (phase == 2 && mem_done) ? 4'(1 << owner) : 4'b0000;
      checks++; if (will_ack_pulse !== exp_will) begin errors++; $display("FAIL rand_will_ack: cycle %0d got %b expected %b", cyc, will_ack_pulse, exp_will); end
      case (phase)
        0: begin
          w = pick(req_valid & ~exp_ack, base);
          if (w >= 0) begin
            phase = 1; owner = w;
            e_addr = req_addr[w]; e_data = req_data[w];
            e_flags = {req_is_stack[w], req_write[w], req_byte[w]};
`ifdef MEM_ARB_ROUND_ROBIN_EN
            base = (w + 1) % 4;
`endif
          end
        end
        1: if (mem_ready) phase = 2;
        default: if (mem_done) phase = 0;
      endcase
      exp_ack = exp_will;
      tick();
      checks++; if (mem_valid !== (phase == 1)) begin errors++; $display("FAIL rand_valid: cycle %0d got %0b expected %0b", cyc, mem_valid, phase == 1); end
      checks++; if (mem_owner !== 2'(owner)) begin errors++; $display("FAIL rand_owner: cycle %0d got %0d expected %0d", cyc, mem_owner, owner); end
      checks++; if ({mem_addr, mem_data, mem_is_stack, mem_write, mem_byte} !== {e_addr, e_data, e_flags}) begin errors++; $display("FAIL rand_fields: cycle %0d got %h/%h/%b expected %h/%h/%b", cyc, mem_addr, mem_data, {mem_is_stack, mem_write, mem_byte}, e_addr, e_data, e_flags); end
      checks++; if (ack_pulse !== exp_ack) begin errors++; $display("FAIL rand_ack: cycle %0d got %b expected %b", cyc, ack_pulse, exp_ack); end
    end
    clear_inputs();
  endtask

  initial begin
    main_reset_n = 1'b0;
    clear_inputs();
    test_reset();
    test_single();
    test_backpressure();
    test_done_ignored();
    test_grant_order();
    test_reset_mid_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
